rr_stream_mux: RTL and testbench

- N-channel, WIDTH-bit streaming multiplexer with valid/ready handshakes on every input and on the output.
- Replaces fixed-select muxing: channel choice comes from an internal round-robin arbiter, not a sel input.
- Optional packet mode holds the grant on one channel until that channel's last beat has been accepted.
- The output is registered, with one cycle of latency and full throughput. It sits between multiple producers and one shared consumer.

---
 rtl/rr_stream_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/rr_stream_mux.sv | 90 +++++++++
 tb/tb_rr_stream_mux.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_stream_pkg.sv
// Shared definitions for the round-robin stream multiplexer and its arbiter.
package rr_stream_pkg;

    // Channel count used when a block is instantiated without overrides.
    localparam int N_CH_DEFAULT = 4;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : rr_stream_pkg

// File: rtl/rr_arbiter.sv
// Rotate-priority encoder: picks the first requester after ptr, or ptr itself
// while a packet lock is held. Purely combinational.
module rr_arbiter
    import rr_stream_pkg::*;
#(
    parameter int N     = N_CH_DEFAULT,
    parameter int PTR_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             lock,
    output logic [PTR_W-1:0] grant,
    output logic             grant_valid
);

    // Adds step to base modulo N, so non-power-of-two counts wrap to 0.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= N) sum = sum - N;
        return PTR_W'(sum);
    endfunction

    // Scan from the farthest candidate back to the nearest so the nearest requester wins.
    always_comb begin
        // NOTE: every output gets a default before any branch, otherwise a path that
        // skips the assignment infers a latch.
        grant       = wrap_add(ptr, 1);
        grant_valid = 1'b0;
        if (lock) begin
            grant       = ptr;
            grant_valid = req[ptr];
        end else begin
            for (int i = N; i >= 1; i--) begin
                if (req[wrap_add(ptr, i)]) begin
                    grant       = wrap_add(ptr, i);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with round-robin arbitration,
// optional packet-hold, and a single registered output stage.
module rr_stream_mux
    import rr_stream_pkg::*;
#(
    parameter int N_CH     = N_CH_DEFAULT,
    parameter int WIDTH    = 8,
    parameter bit PKT_MODE = 1'b0,
    parameter int CH_W     = clog2_min1(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready
);

    logic [CH_W-1:0]  r_ptr;
    logic             r_lock;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic [CH_W-1:0]  r_out_ch;

    logic [CH_W-1:0]  w_sel;
    logic             w_sel_valid;
    logic             w_load_en;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_last;

    rr_arbiter #(
        .N     (N_CH),
        .PTR_W (CH_W)
    ) u_arbiter (
        .req         (in_valid),
        .ptr         (r_ptr),
        .lock        (r_lock),
        .grant       (w_sel),
        .grant_valid (w_sel_valid)
    );

    assign w_load_en = !r_out_valid || out_ready;
    assign w_accept  = w_load_en && w_sel_valid;

    // Only the granted slice is read, so unselected data never reaches the register.
    assign w_sel_data = in_data[int'(w_sel)*WIDTH +: WIDTH];
    assign w_sel_last = in_last[w_sel];

    // One-hot ready on the selected channel whenever the output stage can take a beat.
    always_comb begin
        in_ready        = '0;
        in_ready[w_sel] = w_load_en;
    end

    // Output register, grant pointer and packet lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= CH_W'(N_CH - 1);
            r_lock      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_accept) begin
            // NOTE: sequential state uses non-blocking assignment so every register
            // samples pre-edge values, independent of statement order.
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_last  <= PKT_MODE && w_sel_last;
            r_out_ch    <= w_sel;
            r_ptr       <= w_sel;
            r_lock      <= PKT_MODE && !w_sel_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;

endmodule : rr_stream_mux

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: a 4-channel beat mux, a 4-channel
// packet-mode mux and a 3-channel 16-bit mux share one clock and reset.
module tb_rr_stream_mux;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // 4 channels, 8 bits, beat mode
    logic [3:0]  v4, l4, r4;
    logic [31:0] d4;
    logic        ov4, ol4, ordy4;
    logic [7:0]  od4;
    logic [1:0]  oc4;

    // 4 channels, 8 bits, packet mode
    logic [3:0]  vp, lp, rp;
    logic [31:0] dp;
    logic        ovp, olp, ordyp;
    logic [7:0]  odp;
    logic [1:0]  ocp;

    // 3 channels, 16 bits, beat mode
    logic [2:0]  v3, l3, r3;
    logic [47:0] d3;
    logic        ov3, ol3, ordy3;
    logic [15:0] od3;
    logic [1:0]  oc3;

    rr_stream_mux #(.N_CH(4), .WIDTH(8), .PKT_MODE(1'b0)) u_beat (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(d4), .in_last(l4),
        .in_ready(r4), .out_valid(ov4), .out_data(od4), .out_last(ol4),
        .out_ch(oc4), .out_ready(ordy4)
    );

    rr_stream_mux #(.N_CH(4), .WIDTH(8), .PKT_MODE(1'b1)) u_pkt (
        .clk(clk), .rst_n(rst_n), .in_valid(vp), .in_data(dp), .in_last(lp),
        .in_ready(rp), .out_valid(ovp), .out_data(odp), .out_last(olp),
        .out_ch(ocp), .out_ready(ordyp)
    );

    rr_stream_mux #(.N_CH(3), .WIDTH(16), .PKT_MODE(1'b0)) u_np2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_last(l3),
        .in_ready(r3), .out_valid(ov3), .out_data(od3), .out_last(ol3),
        .out_ch(oc3), .out_ready(ordy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        v4 = '0; l4 = '0; d4 = '0; ordy4 = 1'b1;
        vp = '0; lp = '0; dp = '0; ordyp = 1'b1;
        v3 = '0; l3 = '0; d3 = '0; ordy3 = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        total++;
        if (ov4 !== 1'b0) begin bad++; $display("FAIL reset_valid_async got=%b exp=0", ov4); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if ({ov4, od4, ol4, oc4} !== 12'h000) begin
            bad++; $display("FAIL reset_outputs got=%b/%h/%b/%0d exp=0/00/0/0", ov4, od4, ol4, oc4);
        end
        total++;
        if (r4 !== 4'b0001) begin bad++; $display("FAIL reset_ready4 got=%b exp=0001", r4); end
        total++;
        if (rp !== 4'b0001) begin bad++; $display("FAIL reset_ready_pkt got=%b exp=0001", rp); end
        total++;
        if (r3 !== 3'b001) begin bad++; $display("FAIL reset_ready3 got=%b exp=001", r3); end
    endtask

    task automatic test_latency();
        @(negedge clk);
        v4 = 4'b0100; d4 = 32'h00A5_0000; l4 = 4'b0100; ordy4 = 1'b1;
        #1;
        total++;
        if (r4 !== 4'b0100) begin bad++; $display("FAIL latency_ready got=%b exp=0100", r4); end
        total++;
        if (ov4 !== 1'b0) begin bad++; $display("FAIL latency_early got=%b exp=0", ov4); end
        step();
        v4 = '0; d4 = 32'hFFFF_FFFF;
        total++;
        if ({ov4, od4, oc4, ol4} !== {1'b1, 8'hA5, 2'd2, 1'b0}) begin
            bad++; $display("FAIL latency_out got=%b/%h/%0d/%b exp=1/a5/2/0", ov4, od4, oc4, ol4);
        end
        step();
        total++;
        if ({ov4, od4, oc4} !== {1'b0, 8'hA5, 2'd2}) begin
            bad++; $display("FAIL drain_hold got=%b/%h/%0d exp=0/a5/2", ov4, od4, oc4);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        v4 = 4'b1111; d4 = 32'h1312_1110; l4 = '0; ordy4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if ({ov4, oc4, od4} !== {1'b1, 2'(i % 4), 8'(8'h10 + i % 4)}) begin
                bad++; $display("FAIL rr_beat%0d got=%b/%0d/%h exp=1/%0d/%h", i, ov4, oc4, od4, i % 4, 8'h10 + i % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        // Pointer sits at 3 after the fairness run, so channel 1 is the only candidate.
        @(negedge clk);
        v4 = 4'b0010; d4 = 32'h0000_2200; ordy4 = 1'b1;
        step();
        v4 = 4'b1111; d4 = 32'h3332_3130; ordy4 = 1'b0;
        #1;
        total++;
        if ({ov4, od4, oc4} !== {1'b1, 8'h22, 2'd1}) begin
            bad++; $display("FAIL bp_load got=%b/%h/%0d exp=1/22/1", ov4, od4, oc4);
        end
        total++;
        if (r4 !== 4'b0000) begin bad++; $display("FAIL bp_ready0 got=%b exp=0000", r4); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({ov4, od4, oc4, r4} !== {1'b1, 8'h22, 2'd1, 4'b0000}) begin
                bad++; $display("FAIL bp_stall%0d got=%b/%h/%0d/%b exp=1/22/1/0000", i, ov4, od4, oc4, r4);
            end
        end
        ordy4 = 1'b1;
        #1;
        total++;
        if (r4 !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got=%b exp=0100", r4); end
        step();
        total++;
        if ({ov4, od4, oc4} !== {1'b1, 8'h32, 2'd2}) begin
            bad++; $display("FAIL bp_no_bubble got=%b/%h/%0d exp=1/32/2", ov4, od4, oc4);
        end
        v4 = '0;
    endtask

    task automatic test_packet_lock();
        do_reset();
        // Single-beat packet on ch0 leaves the pointer at 0 with no lock.
        vp = 4'b0001; dp = 32'h0000_00C0; lp = 4'b0001; ordyp = 1'b1;
        step();
        total++;
        if ({ovp, ocp, odp, olp} !== {1'b1, 2'd0, 8'hC0, 1'b1}) begin
            bad++; $display("FAIL pkt_single got=%b/%0d/%h/%b exp=1/0/c0/1", ovp, ocp, odp, olp);
        end
        vp = 4'b1011; dp = 32'hD300_B1C0; lp = 4'b1001;
        #1;
        total++;
        if (rp !== 4'b0010) begin bad++; $display("FAIL pkt_rr_after_single got=%b exp=0010", rp); end
        step();
        total++;
        if ({ocp, odp, olp} !== {2'd1, 8'hB1, 1'b0}) begin
            bad++; $display("FAIL pkt_beat1 got=%0d/%h/%b exp=1/b1/0", ocp, odp, olp);
        end
        vp = 4'b1001;
        #1;
        total++;
        if (rp !== 4'b0010) begin bad++; $display("FAIL pkt_gap_ready got=%b exp=0010", rp); end
        step();
        total++;
        if (ovp !== 1'b0) begin bad++; $display("FAIL pkt_gap_bubble got=%b exp=0", ovp); end
        vp = 4'b1011; dp = 32'hD300_B2C0;
        step();
        total++;
        if ({ovp, ocp, odp, olp} !== {1'b1, 2'd1, 8'hB2, 1'b0}) begin
            bad++; $display("FAIL pkt_beat2 got=%b/%0d/%h/%b exp=1/1/b2/0", ovp, ocp, odp, olp);
        end
        dp = 32'hD300_B3C0; lp = 4'b1011;
        step();
        total++;
        if ({ocp, odp, olp} !== {2'd1, 8'hB3, 1'b1}) begin
            bad++; $display("FAIL pkt_beat3 got=%0d/%h/%b exp=1/b3/1", ocp, odp, olp);
        end
        vp = 4'b1001;
        step();
        total++;
        if ({ovp, ocp, odp} !== {1'b1, 2'd3, 8'hD3}) begin
            bad++; $display("FAIL pkt_next3 got=%b/%0d/%h exp=1/3/d3", ovp, ocp, odp);
        end
        step();
        total++;
        if ({ovp, ocp, odp} !== {1'b1, 2'd0, 8'hC0}) begin
            bad++; $display("FAIL pkt_next0 got=%b/%0d/%h exp=1/0/c0", ovp, ocp, odp);
        end
        vp = '0;
    endtask

    task automatic test_non_pow2();
        do_reset();
        v3 = 3'b111; d3 = 48'h2002_1001_0000; ordy3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({ov3, oc3, od3} !== {1'b1, 2'(i % 3), 16'((i % 3) * 16'h1001)}) begin
                bad++; $display("FAIL np2_beat%0d got=%b/%0d/%h exp=1/%0d/%h", i, ov3, oc3, od3, i % 3, (i % 3) * 16'h1001);
            end
        end
        v3 = '0;
    endtask

    task automatic test_async_reset_mid_packet();
        do_reset();
        vp = 4'b0100; dp = 32'h00E1_0000; lp = '0; ordyp = 1'b1;
        step();
        dp = 32'h00E2_0000;
        step();
        total++;
        if ({ovp, ocp, odp} !== {1'b1, 2'd2, 8'hE2}) begin
            bad++; $display("FAIL mid_beat2 got=%b/%0d/%h exp=1/2/e2", ovp, ocp, odp);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ovp, ocp, odp} !== {1'b0, 2'd0, 8'h00}) begin
            bad++; $display("FAIL mid_async_clear got=%b/%0d/%h exp=0/0/00", ovp, ocp, odp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        vp = 4'b0101; dp = 32'h00E3_00F0; lp = '0;
        #1;
        total++;
        if (rp !== 4'b0001) begin bad++; $display("FAIL mid_unlock_ready got=%b exp=0001", rp); end
        step();
        total++;
        if ({ovp, ocp, odp} !== {1'b1, 2'd0, 8'hF0}) begin
            bad++; $display("FAIL mid_first_grant got=%b/%0d/%h exp=1/0/f0", ovp, ocp, odp);
        end
        vp = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        clear_inputs();
        test_reset();
        test_latency();
        test_round_robin();
        test_backpressure();
        test_packet_lock();
        test_non_pow2();
        test_async_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_stream_mux
